// File: rtl/i2s_mic_rx.sv
// i2s_mic_rx: master-mode I2S receiver for a MEMS microphone.
// Generates bclk/lrclk from clk and captures one channel of the mic word.
// The word is reduced to signed 16-bit PCM and presented with a single-cycle audio_valid pulse.
// Optional build macro MIC_ROUND_EN: round-half-up (with positive saturation)
// before the reduction to 16 bits; without it the word is simply truncated.
module i2s_mic_rx #(
    parameter int CLK_DIV       = 12,   // clk cycles per bclk half-period, >= 3
    parameter int DATA_BITS     = 24,   // valid mic bits per word, 16..31
    parameter int CHANNEL       = 0,    // 0 = left (lrclk low), 1 = right (lrclk high)
    parameter int WARMUP_FRAMES = 4     // frames discarded after each start, 0..255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        sd_in,
    output logic        bclk,
    output logic        lrclk,
    output logic [15:0] pcm_out,
    output logic        audio_valid
);

    localparam int              DIV_W     = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [4:0]      LAST_SLOT = 5'(DATA_BITS);
    localparam logic            CH_HALF   = (CHANNEL != 0);
    localparam logic [7:0]      WARM_LAST = 8'(WARMUP_FRAMES - 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_WARMUP = 2'd1;
    localparam logic [1:0] ST_RUN    = 2'd2;

    logic [1:0]           state_reg;
    logic [DIV_W-1:0]     div_cnt_reg;
    logic                 bclk_reg;
    logic [5:0]           bit_cnt_reg;
    logic [7:0]           warm_cnt_reg;
    logic                 sd_meta_reg;
    logic                 sd_sync_reg;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 cap_reg;
    logic [15:0]          pcm_reg;
    logic                 valid_reg;

    // Clocks start in the same cycle enable is first seen so bclk rises within CLK_DIV clk.
    logic       clocks_on;
    logic       tick;
    logic       fall_evt;
    logic       frame_end;
    logic [4:0] slot;
    logic       in_half;
    logic       shift_clr;
    logic       shift_en;
    logic       capture_evt;

    assign clocks_on   = (state_reg != ST_IDLE) || enable;
    assign tick        = clocks_on && (div_cnt_reg == DIV_LAST);
    assign fall_evt    = tick && bclk_reg;
    assign frame_end   = fall_evt && (bit_cnt_reg == 6'd63);
    assign slot        = bit_cnt_reg[4:0];
    assign in_half     = (bit_cnt_reg[5] == CH_HALF);
    assign shift_clr   = fall_evt && in_half && (slot == 5'd0);
    assign shift_en    = fall_evt && in_half && (slot != 5'd0) && (slot <= LAST_SLOT);
    assign capture_evt = shift_en && (slot == LAST_SLOT) && (state_reg == ST_RUN);

    assign bclk        = bclk_reg;
    assign lrclk       = bit_cnt_reg[5];
    assign pcm_out     = pcm_reg;
    assign audio_valid = valid_reg;

    // Reduction of the assembled word to 16 bits.
    logic [15:0] trunc_w;
    logic [15:0] reduced_w;
    logic        shift_unused;

    assign trunc_w      = shift_reg[DATA_BITS-1 -: 16];
    assign shift_unused = ^shift_reg;

`ifdef MIC_ROUND_EN
    generate
        if (DATA_BITS > 16) begin : g_round
            logic round_bit;
            assign round_bit = shift_reg[DATA_BITS-17];
            // Round half up; +1 on 16'h7FFF would wrap negative, so hold at full scale.
            assign reduced_w = (round_bit && (trunc_w != 16'h7FFF)) ? trunc_w + 16'd1 : trunc_w;
        end else begin : g_pass
            assign reduced_w = trunc_w;
        end
    endgenerate
`else
    assign reduced_w = trunc_w;
`endif

    // Run-state FSM: warm-up frame counting and stop at the end of the current frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= ST_IDLE;
            warm_cnt_reg <= 8'd0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    warm_cnt_reg <= 8'd0;
                    if (enable) begin
                        state_reg <= (WARMUP_FRAMES == 0) ? ST_RUN : ST_WARMUP;
                    end
                end
                ST_WARMUP: begin
                    if (frame_end) begin
                        if (!enable) begin
                            state_reg <= ST_IDLE;
                        end else if (warm_cnt_reg == WARM_LAST) begin
                            state_reg <= ST_RUN;
                        end else begin
                            warm_cnt_reg <= warm_cnt_reg + 8'd1;
                        end
                    end
                end
                ST_RUN: begin
                    if (frame_end && !enable) begin
                        state_reg <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    // bclk divider and frame bit counter; a frame always ends with bclk low and bit_cnt at 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt_reg <= '0;
            bclk_reg    <= 1'b0;
            bit_cnt_reg <= 6'd0;
        end else if (!clocks_on) begin
            div_cnt_reg <= '0;
            bclk_reg    <= 1'b0;
            bit_cnt_reg <= 6'd0;
        end else if (tick) begin
            div_cnt_reg <= '0;
            bclk_reg    <= ~bclk_reg;
            if (fall_evt) begin
                bit_cnt_reg <= bit_cnt_reg + 6'd1;
            end
        end else begin
            div_cnt_reg <= div_cnt_reg + 1'b1;
        end
    end

    // Two-flop synchroniser for the mic data line.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sd_meta_reg <= 1'b0;
            sd_sync_reg <= 1'b0;
        end else begin
            sd_meta_reg <= sd_in;
            sd_sync_reg <= sd_meta_reg;
        end
    end

    // Deserialiser: cleared on the delay slot, then MSB-first shift of the data slots.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shift_reg <= '0;
        end else if (shift_clr) begin
            shift_reg <= '0;
        end else if (shift_en) begin
            shift_reg <= {shift_reg[DATA_BITS-2:0], sd_sync_reg};
        end
    end

    // Output stage: one clk after the last data bit, update pcm_out and pulse audio_valid.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cap_reg   <= 1'b0;
            pcm_reg   <= 16'd0;
            valid_reg <= 1'b0;
        end else begin
            cap_reg   <= capture_evt;
            valid_reg <= cap_reg;
            if (cap_reg) begin
                pcm_reg <= reduced_w;
            end
        end
    end

endmodule
